// File: rtl/alu_z_stage.sv
// ---------------------------------------------------------------------------
// alu_z_stage
//
// Result-capture stage sitting directly after the ALU. Each accepted ALU
// result is registered into the Z register pair (ZLow / ZHigh) together
// with zero/negative condition flags. The result is then presented on the
// datapath bus as one beat (narrow ops) or two beats, LO then HI (MUL/DIV).
// Both sides use a valid/ready handshake.
//
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-high reset
//   alu_lo     ALU result low half (only half used by narrow ops)
//   alu_hi     ALU result high half (wide ops only)
//   alu_op     opcode of the offered result
//   alu_valid  ALU result offered this cycle
//   alu_ready  stage accepts the offered result this cycle
//   bus_data   current outgoing beat (0 when bus_valid is low)
//   bus_valid  bus_data valid
//   bus_hi     current beat is the HI half
//   bus_ready  consumer accepts the current beat
//   z_lo       ZLow register
//   z_hi       ZHigh register (zero after a narrow op)
//   z_flag     captured result is zero
//   n_flag     captured result is negative
// ---------------------------------------------------------------------------
module alu_z_stage #(
    parameter int          WIDTH  = 32,
    parameter logic [3:0]  MUL_OP = 4'b0110,
    parameter logic [3:0]  DIV_OP = 4'b0111
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [3:0]       alu_op,
    input  logic             alu_valid,
    output logic             alu_ready,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid,
    output logic             bus_hi,
    input  logic             bus_ready,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             z_flag,
    output logic             n_flag
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND_LO = 2'd1;
    localparam logic [1:0] SEND_HI = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       wide_q;     // captured result has a HI beat to send
    logic       in_wide;    // offered result is a wide op
    logic       capture;

    assign in_wide = (alu_op == MUL_OP) || (alu_op == DIV_OP);

    // A new result can enter whenever the stage is empty or its last pending
    // beat leaves this cycle. Deliberately independent of alu_valid, so the
    // only combinational path through the block is bus_ready -> alu_ready.
    assign alu_ready = (state == IDLE)
                    || (state == SEND_LO && !wide_q && bus_ready)
                    || (state == SEND_HI && bus_ready);

    assign capture = alu_valid && alu_ready;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) state_next = SEND_LO;
            end
            SEND_LO: begin
                if (bus_ready) begin
                    if (wide_q)       state_next = SEND_HI;
                    else if (capture) state_next = SEND_LO;
                    else              state_next = IDLE;
                end
            end
            SEND_HI: begin
                if (bus_ready) state_next = capture ? SEND_LO : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            wide_q <= 1'b0;
            z_lo   <= '0;
            z_hi   <= '0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                wide_q <= in_wide;
                z_lo   <= alu_lo;
                // Flags come from the incoming values, so they are valid in
                // the same cycle the LO beat first appears.
                if (in_wide) begin
                    z_hi   <= alu_hi;
                    z_flag <= ({alu_hi, alu_lo} == '0);
                    n_flag <= alu_hi[WIDTH-1];
                end else begin
                    z_hi   <= '0;
                    z_flag <= (alu_lo == '0);
                    n_flag <= alu_lo[WIDTH-1];
                end
            end
        end
    end

    // Bus outputs decode only registered state, keeping alu_* data off any
    // combinational path to the bus. Idle bus reads as all zeros.
    always_comb begin
        bus_valid = 1'b0;
        bus_hi    = 1'b0;
        bus_data  = '0;
        case (state)
            SEND_LO: begin
                bus_valid = 1'b1;
                bus_data  = z_lo;
            end
            SEND_HI: begin
                bus_valid = 1'b1;
                bus_hi    = 1'b1;
                bus_data  = z_hi;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_z_stage.md
# alu_z_stage

Result-capture stage directly downstream of the ALU. Registers each ALU result, including the 64-bit HI/LO pair produced by MUL/DIV, into the Z register pair. Derives zero/negative condition flags. Presents the result to the datapath bus as one 32-bit beat (narrow ops) or two beats, LO then HI (wide ops), under a valid/ready handshake on both sides.

## Interface

Parameters:
- WIDTH, 32, bus and Z-half width
- MUL_OP, 4'b0110, opcode producing a wide result
- DIV_OP, 4'b0111, opcode producing a wide result

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- alu_lo  in  WIDTH  ALU result low half; the only result half for narrow ops
- alu_hi  in  WIDTH  ALU result high half; ignored for narrow ops
- alu_op  in  4  opcode of the result being offered
- alu_valid  in  1  ALU result offered this cycle
- alu_ready  out  1  stage accepts the offered result this cycle
- bus_data  out  WIDTH  current outgoing beat
- bus_valid  out  1  bus_data valid
- bus_hi  out  1  current beat is the HI half
- bus_ready  in  1  consumer accepts the current beat
- z_lo  out  WIDTH  ZLow register
- z_hi  out  WIDTH  ZHigh register; zero after a narrow op
- z_flag  out  1  captured result is zero
- n_flag  out  1  captured result is negative

## Operation

- Wide op: alu_op == MUL_OP or alu_op == DIV_OP. Every other opcode, including unused codes, is narrow.
- Capture occurs when alu_valid && alu_ready at the rising edge. On capture:
  - z_lo <= alu_lo.
  - z_hi <= alu_hi for a wide op; z_hi <= 0 for a narrow op.
  - The wide bit is latched.
  - Flags update at the same edge, computed from the incoming values:
    - z_flag = (alu_lo == 0) for narrow; ({alu_hi, alu_lo} == 0) for wide.
    - n_flag = alu_lo[WIDTH-1] for narrow; alu_hi[WIDTH-1] for wide.
- States:
  - IDLE: bus_valid=0. Capture moves to SEND_LO.
  - SEND_LO: bus_valid=1, bus_data=z_lo, bus_hi=0. When bus_ready:
    - wide: go to SEND_HI.
    - narrow, with a new capture in the same cycle: stay in SEND_LO.
    - narrow, no new capture: go to IDLE.
  - SEND_HI: bus_valid=1, bus_data=z_hi, bus_hi=1. When bus_ready: capture in the same cycle goes to SEND_LO; no capture goes to IDLE.
- alu_ready, combinational: (state==IDLE) || (state==SEND_LO && !wide && bus_ready) || (state==SEND_HI && bus_ready).
  - alu_ready never depends on alu_valid.
  - This allows back-to-back results with no bubble.
- While bus_valid && !bus_ready, the following hold stable: bus_data, bus_hi, z_lo, z_hi, flags, state.
- z_lo, z_hi and the flags keep their last captured values in IDLE, so the rest of the datapath can read them.
- When bus_valid=0, bus_data is 0 and bus_hi is 0.

## Timing

- Reset:
  - clear sampled high at a rising edge puts the block in IDLE.
  - z_lo=0, z_hi=0, z_flag=0, n_flag=0, bus_valid=0, bus_hi=0, bus_data=0.
  - alu_ready=1 in the cycle after the edge.
  - clear overrides any capture or handshake in the same cycle.
- A clear in the middle of a transfer, including in SEND_HI, discards the pending beats.
- Latency: capture at edge N gives bus_valid=1 with the LO beat during cycle N+1.
- Narrow op with bus_ready held high: one beat per cycle; sustained throughput is 1 result/cycle.
- Wide op: LO beat at N+1, HI beat at N+2 at the earliest. Sustained throughput is 1 result per 2 cycles.
- No combinational path from alu_* data inputs to bus_* outputs. The only combinational path is bus_ready -> alu_ready.

## Test plan

- Narrow AND: after clear, offer alu_op=0000, alu_lo=32'h0000_00F0, alu_hi=32'hDEAD_BEEF, with bus_ready=1.
  - Next cycle: bus_valid=1, bus_data=32'h0000_00F0, bus_hi=0.
  - z_hi=0, z_flag=0, n_flag=0.
  - The cycle after: bus_valid=0.
- Wide MUL with backpressure: offer op=0110, lo=32'h0000_0001, hi=32'h8000_0000, with bus_ready=0 for 3 cycles then 1.
  - LO beat held unchanged for 3 cycles, then accepted.
  - Next cycle: HI beat bus_data=32'h8000_0000, bus_hi=1.
  - n_flag=1, z_flag=0.
  - alu_ready=0 throughout the stall.
- Back-to-back narrow: alu_valid=1 for 4 cycles with lo=1,2,3,4 and bus_ready=1.
  - bus_data reads 1,2,3,4 on consecutive cycles with no bubble.
  - alu_ready stays 1.
- Zero flag:
  - Wide DIV with lo=0, hi=0: z_flag=1, n_flag=0, two beats of 0.
  - Narrow op with lo=0, hi=32'hFFFF_FFFF: z_flag=1 and z_hi=0, because hi is ignored.
- Clear mid-transfer: during SEND_HI of a wide op with bus_ready=0, assert clear for one cycle.
  - Next cycle: bus_valid=0, z_lo=z_hi=0, flags=0, alu_ready=1.
  - The HI beat is never delivered.
- Unused opcode 4'b1111 with lo=32'hFFFF_FFFF: treated as narrow, giving one beat, n_flag=1, z_hi=0.
